// File: rtl/if_queue_stage_if.sv
// if_queue_stage_if
//   Bundles the fetch-queue handshakes that sit between preIF, the
//   instruction SRAM response path and the ID stage.
//   Signals:
//     issue_valid / issue_pc / issue_ex / issue_ex_code : entry offered by preIF
//     issue_ready                                       : queue accepts the entry
//     inst_sram_data_ok / inst_sram_rdata               : in-order SRAM responses
//     id_allowin                                        : ID accepts an entry
//     if_to_id_valid / if_to_id_bus                     : head entry towards ID
//     flush                                             : redirect, discards queue
//     drop_pending                                      : stale responses still due
//   Modports:
//     master : the environment around the queue (preIF, SRAM, ID, redirect)
//     slave  : the fetch queue itself
interface if_queue_stage_if #(
  parameter int EXC_W = 15
);
  logic              issue_valid;
  logic [31:0]       issue_pc;
  logic              issue_ex;
  logic [EXC_W-1:0]  issue_ex_code;
  logic              issue_ready;
  logic              inst_sram_data_ok;
  logic [31:0]       inst_sram_rdata;
  logic              id_allowin;
  logic              if_to_id_valid;
  logic [64+EXC_W:0] if_to_id_bus;
  logic              flush;
  logic              drop_pending;

  modport master (
    output issue_valid, issue_pc, issue_ex, issue_ex_code,
    output inst_sram_data_ok, inst_sram_rdata,
    output id_allowin, flush,
    input  issue_ready, if_to_id_valid, if_to_id_bus, drop_pending
  );

  modport slave (
    input  issue_valid, issue_pc, issue_ex, issue_ex_code,
    input  inst_sram_data_ok, inst_sram_rdata,
    input  id_allowin, flush,
    output issue_ready, if_to_id_valid, if_to_id_bus, drop_pending
  );
endinterface

// File: rtl/if_queue_stage.sv
// if_queue_stage
//   Instruction-fetch queue. preIF pushes {pc, ex, ex_code} when it sends
//   an SRAM request (or when it raised an exception and sent none). SRAM
//   responses come back in order and fill the oldest unfinished entry. The
//   head entry is offered to ID once it is complete. A flush throws the
//   queue away and remembers how many responses are still in flight so
//   they can be discarded when they arrive.
//   Ports:
//     clk   : clock, all state on the rising edge
//     reset : asynchronous, active-high reset
//     fq    : if_queue_stage_if.slave handshake bundle
//   Parameters:
//     DEPTH : entry count, power of two in 2..16
//     EXC_W : exception-code width
module if_queue_stage #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 15
) (
  input logic             clk,
  input logic             reset,
  if_queue_stage_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = AW + 2;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } drop_state_t;

  // Entry payload: not reset, only read while the entry is live.
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [EXC_W-1:0] code_mem [DEPTH];
  logic [DEPTH-1:0] ex_reg;

  logic [DEPTH-1:0] done_reg, done_next;
  logic [AW-1:0]    head_reg, head_next;
  logic [AW-1:0]    tail_reg, tail_next;
  logic [AW-1:0]    fill_reg, fill_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [DW-1:0]    drop_cnt_reg, drop_cnt_next;
  logic [DW:0]      drop_sum;
  drop_state_t      state_reg, state_next;
  logic             stray_seen_reg;

  logic [DEPTH-1:0] live_now, live_next, stale_vec;
  logic [CW-1:0]    stale_cnt;
  logic [AW-1:0]    scan_idx;
  logic             issue_ready_int, valid_int;
  logic             issue_fire, pop_fire, fill_fire, stray_ok;

  // An entry is live when its distance from head is below the occupancy.
  // Using offsets from head avoids the full/empty ambiguity of equal pointers.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      logic [AW-1:0] off_now;
      logic [AW-1:0] off_next;
      assign off_now       = AW'(gi) - head_reg;
      assign off_next      = AW'(gi) - head_next;
      assign live_now[gi]  = ({1'b0, off_now} < count_reg);
      assign live_next[gi] = ({1'b0, off_next} < count_next);
    end
  endgenerate

  // ex entries are created done, so "not done" already implies "real request".
  assign stale_vec = live_now & ~done_reg & ~ex_reg;

  assign issue_ready_int = !reset && !fq.flush && (count_reg != CW'(DEPTH));
  assign valid_int       = (count_reg != '0) && done_reg[head_reg] && !fq.flush;

  assign issue_fire = fq.issue_valid && issue_ready_int;
  assign pop_fire   = valid_int && fq.id_allowin;
  assign fill_fire  = fq.inst_sram_data_ok && !fq.flush && (state_reg == RUN) && (stale_cnt != '0);
  // A response with nothing outstanding and nothing to drop is ignored.
  assign stray_ok   = fq.inst_sram_data_ok && (state_reg == RUN) && (stale_cnt == '0);

  assign fq.issue_ready    = issue_ready_int;
  assign fq.if_to_id_valid = valid_int;
  assign fq.if_to_id_bus   = {pc_mem[head_reg],
                              ex_reg[head_reg] ? 32'h0 : inst_mem[head_reg],
                              ex_reg[head_reg],
                              code_mem[head_reg]};
  assign fq.drop_pending   = (drop_cnt_reg != '0);

  // Pointers, occupancy, done bits and drop counter.
  always_comb begin
    stale_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stale_cnt = stale_cnt + CW'(stale_vec[i]);
    end

    done_next = done_reg;
    if (fill_fire) begin
      done_next[fill_reg] = 1'b1;
    end
    if (issue_fire) begin
      done_next[tail_reg] = fq.issue_ex;
    end

    head_next  = head_reg + AW'(pop_fire);
    tail_next  = tail_reg + AW'(issue_fire);
    count_next = count_reg + CW'(issue_fire) - CW'(pop_fire);
    if (fq.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end

    // Stale responses still owed plus those orphaned by this flush; a
    // response in this cycle consumes one of them.
    drop_sum = (DW+1)'(drop_cnt_reg);
    if (fq.flush) begin
      drop_sum = drop_sum + (DW+1)'(stale_cnt);
    end
    if (fq.inst_sram_data_ok && (drop_sum != '0)) begin
      drop_sum = drop_sum - (DW+1)'(1);
    end
    if (drop_sum > (DW+1)'(2 * DEPTH)) begin
      drop_cnt_next = DW'(2 * DEPTH);
    end else begin
      drop_cnt_next = drop_sum[DW-1:0];
    end
  end

  // Fill pointer: first live, unfinished entry counted from the new head;
  // falls back to tail when everything live is complete.
  always_comb begin
    fill_next = tail_next;
    scan_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx = head_next + AW'(i);
      if (live_next[scan_idx] && !done_next[scan_idx]) begin
        fill_next = scan_idx;
      end
    end
  end

  // Drop FSM next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (drop_cnt_next != '0) state_next = DRAIN;
      DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      fill_reg       <= '0;
      count_reg      <= '0;
      drop_cnt_reg   <= '0;
      done_reg       <= '0;
      state_reg      <= RUN;
      stray_seen_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      fill_reg     <= fill_next;
      count_reg    <= count_next;
      drop_cnt_reg <= drop_cnt_next;
      done_reg     <= done_next;
      state_reg    <= state_next;
      if (stray_ok) begin
        stray_seen_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      pc_mem[tail_reg]   <= fq.issue_pc;
      code_mem[tail_reg] <= fq.issue_ex_code;
      ex_reg[tail_reg]   <= fq.issue_ex;
    end
    if (fill_fire) begin
      inst_mem[fill_reg] <= fq.inst_sram_rdata;
    end
  end

  // Reports the first unexpected response; the flag stays set afterwards.
  stray_response_check : assert property (
    @(posedge clk) disable iff (reset) !(stray_ok && !stray_seen_reg)
  ) else $warning("if_queue_stage: response with no outstanding request ignored");

endmodule

// File: tb/tb_if_queue_stage.sv
// tb_if_queue_stage
//   Directed-vector bench for if_queue_stage (DEPTH=4, EXC_W=15).
//   Ports: none (top level).
module tb_if_queue_stage;
  localparam int DEPTH = 4;
  localparam int EXC_W = 15;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  if_queue_stage_if #(.EXC_W(EXC_W)) fq ();

  if_queue_stage #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [95:0] id_word(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic ex, input logic [EXC_W-1:0] code);
    return 96'({pc, inst, ex, code});
  endfunction

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ex,
                       input logic [EXC_W-1:0] code, input logic dok,
                       input logic [31:0] rdata, input logic alw, input logic fl);
    fq.issue_valid       = iv;
    fq.issue_pc          = pc;
    fq.issue_ex          = ex;
    fq.issue_ex_code     = code;
    fq.inst_sram_data_ok = dok;
    fq.inst_sram_rdata   = rdata;
    fq.id_allowin        = alw;
    fq.flush             = fl;
  endtask

  task automatic idle(input logic alw);
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b0, 32'h0, alw, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h1C000000, 1'b0, 15'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_issue_ready", 96'(fq.issue_ready), 0);
    check_vec("rst_valid", 96'(fq.if_to_id_valid), 0);
    check_vec("rst_drop_pending", 96'(fq.drop_pending), 0);
    check_vec("rst_count", 96'(dut.count_reg), 0);
    idle(1'b0);
    reset = 1'b0;
    tick();

    // Single fetch, best-case latency.
    drive(1'b1, 32'h1C000000, 1'b0, 15'h0, 1'b0, 32'h0, 1'b1, 1'b0); #1;
    check_vec("t1_ready", 96'(fq.issue_ready), 1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h02800000, 1'b1, 1'b0); #1;
    check_vec("t1_not_yet_valid", 96'(fq.if_to_id_valid), 0);
    tick();
    idle(1'b1); #1;
    check_vec("t1_valid", 96'(fq.if_to_id_valid), 1);
    check_vec("t1_bus", 96'(fq.if_to_id_bus), id_word(32'h1C000000, 32'h02800000, 1'b0, 15'h0));
    tick();
    check_vec("t1_count", 96'(dut.count_reg), 0);
    check_vec("t1_empty_valid", 96'(fq.if_to_id_valid), 0);

    // Fill to capacity, fifth issue refused, pops in order.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h1C000200 + 32'(k * 4), 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check_vec($sformatf("t2_ready_%0d", k), 96'(fq.issue_ready), (k < 4) ? 1 : 0);
      tick();
    end
    idle(1'b0); #1;
    check_vec("t2_count_full", 96'(dut.count_reg), 4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    // Pop and issue together while full: the issue must still be refused.
    drive(1'b1, 32'h1C000999, 1'b0, 15'h0, 1'b0, 32'h0, 1'b1, 1'b0); #1;
    check_vec("t2_full_no_bypass", 96'(fq.issue_ready), 0);
    check_vec("t2_pop_0", 96'(fq.if_to_id_bus), id_word(32'h1C000200, 32'hA0, 1'b0, 15'h0));
    tick();
    for (int k = 1; k < 4; k++) begin
      idle(1'b1); #1;
      check_vec($sformatf("t2_pop_%0d", k), 96'(fq.if_to_id_bus),
                id_word(32'h1C000200 + 32'(k * 4), 32'hA0 + 32'(k), 1'b0, 15'h0));
      tick();
    end
    check_vec("t2_count_empty", 96'(dut.count_reg), 0);

    // Flush with three outstanding, issue during drain.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1C000300 + 32'(k * 4), 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b0, 32'h0, 1'b1, 1'b1); #1;
    check_vec("t3_flush_ready", 96'(fq.issue_ready), 0);
    tick();
    idle(1'b1); #1;
    check_vec("t3_drop_cnt", 96'(dut.drop_cnt_reg), 3);
    check_vec("t3_drop_pending", 96'(fq.drop_pending), 1);
    check_vec("t3_count", 96'(dut.count_reg), 0);
    drive(1'b1, 32'h1C000100, 1'b0, 15'h0, 1'b1, 32'hDEAD0001, 1'b1, 1'b0); #1;
    check_vec("t3_ready_in_drain", 96'(fq.issue_ready), 1);
    tick();
    check_vec("t3_drop_cnt_2", 96'(dut.drop_cnt_reg), 2);
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'hDEAD0002, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'hDEAD0003, 1'b1, 1'b0);
    tick();
    check_vec("t3_drained", 96'(fq.drop_pending), 0);
    check_vec("t3_not_filled", 96'(fq.if_to_id_valid), 0);
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h00000123, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t3_bus", 96'(fq.if_to_id_bus), id_word(32'h1C000100, 32'h00000123, 1'b0, 15'h0));
    check_vec("t3_valid", 96'(fq.if_to_id_valid), 1);
    tick();

    // Exception entry queued behind a pending request.
    drive(1'b1, 32'h1C000400, 1'b0, 15'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h1C000404, 1'b1, 15'h0008, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t4_wait_older", 96'(fq.if_to_id_valid), 0);
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h11112222, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t4_older", 96'(fq.if_to_id_bus), id_word(32'h1C000400, 32'h11112222, 1'b0, 15'h0));
    tick();
    check_vec("t4_ex_valid", 96'(fq.if_to_id_valid), 1);
    check_vec("t4_ex_entry", 96'(fq.if_to_id_bus), id_word(32'h1C000404, 32'h0, 1'b1, 15'h0008));
    tick();
    check_vec("t4_count", 96'(dut.count_reg), 0);

    // Flush coincident with a response, two outstanding.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h1C000500 + 32'(k * 4), 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'hBAD00001, 1'b0, 1'b1);
    tick();
    idle(1'b0); #1;
    check_vec("t5_drop_cnt", 96'(dut.drop_cnt_reg), 1);
    drive(1'b1, 32'h1C000508, 1'b0, 15'h0, 1'b1, 32'hBAD00002, 1'b1, 1'b0);
    tick();
    check_vec("t5_drained", 96'(fq.drop_pending), 0);
    check_vec("t5_discarded", 96'(fq.if_to_id_valid), 0);
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h00000055, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t5_bus", 96'(fq.if_to_id_bus), id_word(32'h1C000508, 32'h55, 1'b0, 15'h0));
    tick();

    // Reset while full and draining.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h1C000600 + 32'(k * 4), 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1C000700 + 32'(k * 4), 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0); #1;
    check_vec("t6_full", 96'(dut.count_reg), 4);
    check_vec("t6_drop_cnt", 96'(dut.drop_cnt_reg), 2);
    reset = 1'b1; #1;
    check_vec("t6_rst_count", 96'(dut.count_reg), 0);
    check_vec("t6_rst_drop", 96'(fq.drop_pending), 0);
    check_vec("t6_rst_ready", 96'(fq.issue_ready), 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h00000077, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t6_stray_count", 96'(dut.count_reg), 0);
    check_vec("t6_stray_drop", 96'(fq.drop_pending), 0);
    drive(1'b1, 32'h1C000800, 1'b0, 15'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 15'h0, 1'b1, 32'h00000088, 1'b1, 1'b0);
    tick();
    idle(1'b1); #1;
    check_vec("t6_after_reset_bus", 96'(fq.if_to_id_bus), id_word(32'h1C000800, 32'h88, 1'b0, 15'h0));
    tick();
    check_vec("t6_final_count", 96'(dut.count_reg), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
